message_serializer: RTL

Parametrised byte serializer for the message path. It captures a wide message word, such as the decrypted `out_message` leaving `User`, in one load. It then emits the message one byte per handshake on a valid/ready stream, replacing the fixed 100-byte, MSB-first extraction loop at the output side. It supports configurable message length, byte width and byte order, and optionally strips leading NUL padding.

---
 rtl/msg_ser_pkg.sv | 19 +
 rtl/message_serializer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/msg_ser_pkg.sv
// Shared types and constants for the message byte serializer.
// Imported by message_serializer.
package msg_ser_pkg;

  localparam int MSG_BYTES_DEF = 100;
  localparam int BYTE_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_SEND = 2'd2
  } ser_state_e;

  // Bits needed to hold any count in 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/message_serializer.sv
// Wide-word to byte-stream serializer with valid/ready output.
// Optional macro MSG_SER_NUL_SKIP_EN drops leading NUL padding.
module message_serializer
  import msg_ser_pkg::*;
#(
  parameter int MSG_BYTES = MSG_BYTES_DEF,
  parameter int BYTE_W    = BYTE_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load,
  input  logic [MSG_BYTES*BYTE_W-1:0]      in_message,
  output logic                             load_ready,
  output logic [BYTE_W-1:0]                out_byte,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             done,
  output logic [$clog2(MSG_BYTES+1)-1:0]   remaining
);

  localparam int DW = MSG_BYTES * BYTE_W;
  localparam int CW = cnt_w(MSG_BYTES);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MSG_BYTES);

  ser_state_e          state_q, state_d;
  logic [DW-1:0]       shreg_q, shreg_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic                done_q, done_d;

  logic [DW-1:0]       shifted;
  logic [BYTE_W-1:0]   head;
  logic                is_last;

  // Byte at the emitting end of a message-sized word
  function automatic logic [BYTE_W-1:0] head_of(
    input logic [DW-1:0] v
  );
    if (MSB_FIRST) begin
      return v[DW-1 -: BYTE_W];
    end else begin
      return v[BYTE_W-1:0];
    end
  endfunction

  // Register after consuming the head byte; vacated end is zero-filled
  always_comb begin
    if (MSB_FIRST) begin
      shifted = shreg_q << BYTE_W;
    end else begin
      shifted = shreg_q >> BYTE_W;
    end
  end

  assign head    = head_of(shreg_q);
  assign is_last = (rem_q == CNT_ONE);

  // Next-state, shift and count control
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          shreg_d = in_message;
          rem_d   = CNT_FULL;
`ifdef MSG_SER_NUL_SKIP_EN
          // Entering SKIP only with a NUL head keeps k=0 at N+1
          if (head_of(in_message) == '0) begin
            state_d = ST_SKIP;
          end else begin
            state_d = ST_SEND;
          end
`else
          state_d = ST_SEND;
`endif
        end
      end
`ifdef MSG_SER_NUL_SKIP_EN
      ST_SKIP: begin
        if (head != '0) begin
          state_d = ST_SEND;
        end else if (rem_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          shreg_d = shifted;
          rem_d   = rem_q - CNT_ONE;
          // Look past the dropped byte so SEND starts without a bubble
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (head_of(shifted) != '0) begin
            state_d = ST_SEND;
          end
        end
      end
`endif
      ST_SEND: begin
        if (out_ready) begin
          shreg_d = shifted;
          rem_d   = rem_q - CNT_ONE;
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register, counter and done pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_SEND);
  assign out_byte   = out_valid ? head : '0;
  assign out_last   = out_valid & is_last;
  assign done       = done_q;
  assign remaining  = rem_q;

endmodule
